// File: rtl/ru_wb_arbiter.sv
// RU write-port arbiter: muxes core writeback data, shares the single write
// port with an aux valid/ready source, and bounds aux starvation.
module ru_wb_arbiter #(
  parameter int MAX_WAIT = 3,
  parameter int WAIT_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_we,
  input  logic [4:0]        core_rd,
  input  logic [1:0]        RUDataWrSrc,
  input  logic [31:0]       ALURes,
  input  logic [31:0]       DataRd,
  input  logic [31:0]       PC_with_offset,
  input  logic              aux_valid,
  input  logic [4:0]        aux_rd,
  input  logic [31:0]       aux_data,
  output logic              aux_ready,
  output logic              core_stall,
  output logic              ru_we,
  output logic [4:0]        ru_rd,
  output logic [31:0]       ru_data,
  output logic [WAIT_W-1:0] aux_wait
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

  logic [31:0]       core_data_s;
  logic              aux_win_s;
  logic              core_grant_s;
  logic [4:0]        grant_rd_s;
  logic [31:0]       grant_data_s;
  logic              ru_we_d, ru_we_q;
  logic [4:0]        ru_rd_d, ru_rd_q;
  logic [31:0]       ru_data_d, ru_data_q;
  logic [WAIT_W-1:0] aux_wait_d, aux_wait_q;

  // Core writeback source select
  always_comb begin
    core_data_s = 32'h0000_0000;
    case (RUDataWrSrc)
      2'b00:   core_data_s = ALURes;
      2'b01:   core_data_s = DataRd;
      2'b10:   core_data_s = PC_with_offset;
      2'b11:   core_data_s = 32'h0000_0000;
      default: core_data_s = 32'h0000_0000;
    endcase
  end

  // Grant decision; a same-rd aux result is older and must land first
  always_comb begin
    aux_win_s = 1'b0;
    if (aux_valid) begin
      if (!core_we) begin
        aux_win_s = 1'b1;
      end else if (aux_wait_q == MAX_WAIT_C) begin
        aux_win_s = 1'b1;
      end else if ((aux_rd == core_rd) && (aux_rd != 5'd0)) begin
        aux_win_s = 1'b1;
      end else begin
        aux_win_s = 1'b0;
      end
    end else begin
      aux_win_s = 1'b0;
    end
    core_grant_s = core_we && !aux_win_s;
    aux_ready    = aux_win_s;
    core_stall   = core_we && aux_win_s;
  end

  // Next write-stage state; rd 0 grants complete the handshake but never write
  always_comb begin
    grant_rd_s   = aux_win_s ? aux_rd : core_rd;
    grant_data_s = aux_win_s ? aux_data : core_data_s;
    ru_we_d      = (aux_win_s || core_grant_s) && (grant_rd_s != 5'd0);
    if (ru_we_d) begin
      ru_rd_d   = grant_rd_s;
      ru_data_d = grant_data_s;
    end else begin
      ru_rd_d   = ru_rd_q;
      ru_data_d = ru_data_q;
    end
    if (aux_valid && !aux_win_s) begin
      if (aux_wait_q == MAX_WAIT_C) begin
        aux_wait_d = aux_wait_q;
      end else begin
        aux_wait_d = aux_wait_q + WAIT_ONE;
      end
    end else begin
      aux_wait_d = {WAIT_W{1'b0}};
    end
  end

  // Registered write port and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ru_we_q    <= 1'b0;
      ru_rd_q    <= 5'd0;
      ru_data_q  <= 32'h0000_0000;
      aux_wait_q <= {WAIT_W{1'b0}};
    end else begin
      ru_we_q    <= ru_we_d;
      ru_rd_q    <= ru_rd_d;
      ru_data_q  <= ru_data_d;
      aux_wait_q <= aux_wait_d;
    end
  end

  assign ru_we    = ru_we_q;
  assign ru_rd    = ru_rd_q;
  assign ru_data  = ru_data_q;
  assign aux_wait = aux_wait_q;

endmodule

// File: tb/tb_ru_wb_arbiter.sv
// Scoreboard bench for ru_wb_arbiter: stimulus pushes expected RU writes,
// a negedge monitor pops and compares every ru_we pulse.
module tb_ru_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        core_we;
  logic [4:0]  core_rd;
  logic [1:0]  RUDataWrSrc;
  logic [31:0] ALURes;
  logic [31:0] DataRd;
  logic [31:0] PC_with_offset;
  logic        aux_valid;
  logic [4:0]  aux_rd;
  logic [31:0] aux_data;
  logic        aux_ready;
  logic        core_stall;
  logic        ru_we;
  logic [4:0]  ru_rd;
  logic [31:0] ru_data;
  logic [1:0]  aux_wait;

  int tests;
  int fails;
  logic [36:0] exp_q[$];

  ru_wb_arbiter #(.MAX_WAIT(3), .WAIT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .core_we(core_we), .core_rd(core_rd),
    .RUDataWrSrc(RUDataWrSrc), .ALURes(ALURes), .DataRd(DataRd),
    .PC_with_offset(PC_with_offset), .aux_valid(aux_valid), .aux_rd(aux_rd),
    .aux_data(aux_data), .aux_ready(aux_ready), .core_stall(core_stall),
    .ru_we(ru_we), .ru_rd(ru_rd), .ru_data(ru_data), .aux_wait(aux_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every registered write must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && ru_we) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%0h, expected no write", ru_rd, ru_data);
      end else begin
        chk("ru_write", {ru_rd, ru_data}, exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic cwe, input logic [4:0] crd, input logic [1:0] src,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad);
    core_we = cwe; core_rd = crd; RUDataWrSrc = src;
    aux_valid = av; aux_rd = ard; aux_data = ad;
  endtask

  // One cycle: check handshake outputs and wait count, queue expected write
  task automatic step(input string name, input logic e_ready, input logic e_stall,
                      input logic [1:0] e_wait, input logic e_wr,
                      input logic [4:0] e_rd, input logic [31:0] e_data);
    @(negedge clk);
    chk({name, "_aux_ready"}, {36'd0, aux_ready}, {36'd0, e_ready});
    chk({name, "_core_stall"}, {36'd0, core_stall}, {36'd0, e_stall});
    chk({name, "_aux_wait"}, {35'd0, aux_wait}, {35'd0, e_wait});
    if (e_wr) exp_q.push_back({e_rd, e_data});
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    ALURes = 32'h1234_5678; DataRd = 32'hCAFE_BABE; PC_with_offset = 32'h0000_0040;
    drive(1'b0, 5'd0, 2'b00, 1'b0, 5'd0, 32'h0);
    #2;
    chk("reset_regs", {ru_we, ru_rd, ru_data}, 38'd0);
    chk("reset_wait", {35'd0, aux_wait}, 37'd0);
    chk("reset_idle_ready", {36'd0, aux_ready}, 37'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Core only, all four sources
    drive(1'b1, 5'd5, 2'b00, 1'b0, 5'd0, 32'h0);
    step("core_src0", 1'b0, 1'b0, 2'd0, 1'b1, 5'd5, 32'h1234_5678);
    RUDataWrSrc = 2'b01;
    step("core_src1", 1'b0, 1'b0, 2'd0, 1'b1, 5'd5, 32'hCAFE_BABE);
    RUDataWrSrc = 2'b10;
    step("core_src2", 1'b0, 1'b0, 2'd0, 1'b1, 5'd5, 32'h0000_0040);
    RUDataWrSrc = 2'b11;
    step("core_src3", 1'b0, 1'b0, 2'd0, 1'b1, 5'd5, 32'h0000_0000);

    // Aux only
    drive(1'b0, 5'd0, 2'b00, 1'b1, 5'd7, 32'hDEAD_BEEF);
    step("aux_only", 1'b1, 1'b0, 2'd0, 1'b1, 5'd7, 32'hDEAD_BEEF);
    drive(1'b0, 5'd0, 2'b00, 1'b0, 5'd0, 32'h0);
    step("idle0", 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0);

    // Continuous contention: aux forced through at wait == MAX_WAIT
    drive(1'b1, 5'd3, 2'b00, 1'b1, 5'd9, 32'h1111_1111);
    step("cont0", 1'b0, 1'b0, 2'd0, 1'b1, 5'd3, 32'h1234_5678);
    step("cont1", 1'b0, 1'b0, 2'd1, 1'b1, 5'd3, 32'h1234_5678);
    step("cont2", 1'b0, 1'b0, 2'd2, 1'b1, 5'd3, 32'h1234_5678);
    step("cont3", 1'b1, 1'b1, 2'd3, 1'b1, 5'd9, 32'h1111_1111);
    aux_data = 32'h2222_2222;
    step("cont4", 1'b0, 1'b0, 2'd0, 1'b1, 5'd3, 32'h1234_5678);
    drive(1'b0, 5'd0, 2'b00, 1'b0, 5'd0, 32'h0);
    step("idle1", 1'b0, 1'b0, 2'd1, 1'b0, 5'd0, 32'h0);

    // Same-rd collision: aux first, then the held core write
    drive(1'b1, 5'd4, 2'b01, 1'b1, 5'd4, 32'hA5A5_A5A5);
    step("coll0", 1'b1, 1'b1, 2'd0, 1'b1, 5'd4, 32'hA5A5_A5A5);
    aux_valid = 1'b0;
    step("coll1", 1'b0, 1'b0, 2'd0, 1'b1, 5'd4, 32'hCAFE_BABE);

    // rd 0 grants: handshake completes, no write, data held
    drive(1'b1, 5'd0, 2'b00, 1'b0, 5'd0, 32'h0);
    step("core_rd0", 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0);
    chk("core_rd0_hold", {ru_we, ru_rd, ru_data}, {1'b0, 5'd4, 32'hCAFE_BABE});
    drive(1'b0, 5'd0, 2'b00, 1'b1, 5'd0, 32'h5555_5555);
    step("aux_rd0", 1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0);
    chk("aux_rd0_hold", {ru_we, ru_rd, ru_data}, {1'b0, 5'd4, 32'hCAFE_BABE});

    // Reset mid-contention with aux_wait == 2
    drive(1'b1, 5'd3, 2'b00, 1'b1, 5'd9, 32'h3333_3333);
    step("rst_pre0", 1'b0, 1'b0, 2'd0, 1'b1, 5'd3, 32'h1234_5678);
    step("rst_pre1", 1'b0, 1'b0, 2'd1, 1'b1, 5'd3, 32'h1234_5678);
    chk("rst_pre_state", {ru_we, 34'd0, aux_wait}, {1'b1, 34'd0, 2'd2});
    void'(exp_q.pop_back());
    rst_n = 1'b0;
    #1;
    chk("rst_async_regs", {ru_we, ru_rd, ru_data}, 38'd0);
    chk("rst_async_wait", {35'd0, aux_wait}, 37'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("rst_post0", 1'b0, 1'b0, 2'd0, 1'b1, 5'd3, 32'h1234_5678);
    step("rst_post1", 1'b0, 1'b0, 2'd1, 1'b1, 5'd3, 32'h1234_5678);
    drive(1'b0, 5'd0, 2'b00, 1'b0, 5'd0, 32'h0);
    step("idle2", 1'b0, 1'b0, 2'd2, 1'b0, 5'd0, 32'h0);
    step("idle3", 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0);

    chk("scoreboard_drained", 37'(exp_q.size()), 37'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ru_wb_arbiter.md
Name: ru_wb_arbiter

Overview:
Write-port arbiter and sequencer for the register unit (RU) write path. It selects core writeback data by RUDataWrSrc, shares the single RU write port with an auxiliary multi-cycle result source (mul/div, CSR unit) through a valid/ready handshake, and bounds auxiliary starvation with a wait counter that stalls the core when needed. Outputs are registered and drive the RU write port directly.

Parameters:
MAX_WAIT, 3, max consecutive cycles an asserted aux request is refused before it is forced through (1..2^WAIT_W-1)
WAIT_W, 2, width of wait counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
core_we  input  1  core requests RU write this cycle
core_rd  input  5  core destination register
RUDataWrSrc  input  2  core data select: 00 ALURes, 01 DataRd, 10 PC_with_offset, 11 zero
ALURes  input  32  ALU result
DataRd  input  32  data-memory read data
PC_with_offset  input  32  PC+4 link value
aux_valid  input  1  aux result pending
aux_rd  input  5  aux destination register
aux_data  input  32  aux result
aux_ready  output  1  aux granted this cycle (combinational)
core_stall  output  1  core denied this cycle, must hold inputs (combinational)
ru_we  output  1  registered RU write enable
ru_rd  output  5  registered RU write address
ru_data  output  32  registered RU write data
aux_wait  output  WAIT_W  current wait count (registered)

Behaviour:
- Reset (rst_n low, async): ru_we=0, ru_rd=0, ru_data=0, aux_wait=0. aux_ready and core_stall follow the combinational rules below and are not forced by reset.
- Core data select: 00 ALURes, 01 DataRd, 10 PC_with_offset, 11 32'h0.
- Grant decision, combinational each cycle:
  - No request: no grant.
  - core_we only: grant core.
  - aux_valid only: grant aux, aux_ready=1.
  - Both requesting, core wins unless one of these holds:
    - aux_wait == MAX_WAIT: aux wins.
    - aux_rd == core_rd and aux_rd != 0: aux wins, because the aux result is older and ordering must be preserved.
  - When aux wins over core_we: core_stall=1. core_stall=0 in all other cases.
- Write stage: on the rising edge after a grant, ru_we=1, ru_rd=granted rd, ru_data=granted data. Latency is exactly 1 cycle. With no grant, ru_we=0 and ru_rd/ru_data hold their previous values.
- rd==0 rule: a grant to rd 0 still completes the handshake (aux_ready=1, core not stalled), but ru_we stays 0 and ru_rd/ru_data are not updated.
- aux_wait counter:
  - Increments, saturating at MAX_WAIT, when aux_valid=1 and aux_ready=0.
  - Clears to 0 when aux_ready=1 or aux_valid=0.
- Handshake rules:
  - Aux transfer occurs in a cycle where aux_valid && aux_ready. The aux source holds aux_rd/aux_data stable while aux_valid=1 and not granted.
  - Core holds core_we/core_rd/RUDataWrSrc and the data inputs while core_stall=1. The stalled request is re-arbitrated the next cycle; after a forced aux grant, aux_wait=0, so core wins the next contention.
- Back-to-back: grants may occur every cycle; sustained contention yields at most 1 aux grant per MAX_WAIT+1 cycles unless rd collisions occur.
- Reset mid-operation: an ungranted aux request is not lost (the source still holds valid) and is re-arbitrated after reset. A write registered but not yet consumed by the RU is discarded (ru_we cleared).

Test Plan:
- Core only, src 00/01/10/11 with ALURes=0x12345678, DataRd=0xCAFEBABE, PC_with_offset=0x40, core_rd=5 -> next cycle ru_we=1, ru_rd=5, ru_data=0x12345678/0xCAFEBABE/0x00000040/0x00000000.
- Aux only, aux_rd=7, aux_data=0xDEADBEEF -> aux_ready=1 same cycle; next cycle ru_we=1, ru_rd=7, ru_data=0xDEADBEEF; aux_wait stays 0.
- Continuous contention, core_rd=3, aux_rd=9, MAX_WAIT=3 -> core granted cycles 0-2 (aux_wait 1,2,3); cycle 3 aux_ready=1, core_stall=1; cycle 4 aux_wait=0 and core granted.
- Same-rd collision, core_rd=aux_rd=4 -> aux granted, core_stall=1; next cycle core granted; ru_data sequence is aux_data then core data.
- rd 0: core_we=1, core_rd=0 -> core_stall=0, ru_we stays 0, ru_data unchanged; aux_rd=0 -> aux_ready=1, ru_we=0.
- Assert rst_n low mid-contention with aux_wait=2 -> ru_we/ru_rd/ru_data/aux_wait go to 0 immediately (async). After release, aux still valid -> counting restarts from 0.
